// File: rtl/burst_write_ctrl.sv
// Burst write controller: accepts a base/length command, streams data beats into RAM port A.
// Optional readback verification of the burst is enabled by defining BURST_READBACK_CHECK_EN.
module burst_write_ctrl #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          wea,
  output logic [AW-1:0] addra,
  output logic [DW-1:0] dia,
  input  logic [DW-1:0] doa,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

`ifdef BURST_READBACK_CHECK_EN
  typedef enum logic [2:0] {IDLE, WRITE, VERIFY, CHECK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [AW-1:0] remaining_q, remaining_d;

`ifdef BURST_READBACK_CHECK_EN
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] len_q, len_d;
  logic [DW-1:0] checksum_q, checksum_d;
  logic [DW-1:0] rd_sum_q, rd_sum_d;
  logic          err_q, err_d;

  assign err = err_q;
`else
  logic doa_unused;

  assign doa_unused = ^doa;
  assign err        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
`ifdef BURST_READBACK_CHECK_EN
    base_d      = base_q;
    len_d       = len_q;
    checksum_d  = checksum_q;
    rd_sum_d    = rd_sum_q;
    err_d       = err_q;
`endif
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;
    wea         = 1'b0;
    addra       = cur_addr_q;
    dia         = '0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d     = WRITE;
          cur_addr_d  = cmd_addr;
          remaining_d = cmd_len;
`ifdef BURST_READBACK_CHECK_EN
          base_d      = cmd_addr;
          len_d       = cmd_len;
          checksum_d  = '0;
          rd_sum_d    = '0;
          err_d       = 1'b0;
`endif
        end
      end

      WRITE: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        wea      = in_valid;
        if (in_valid) begin
          dia         = in_data;
          cur_addr_d  = cur_addr_q + ADDR_ONE;
          remaining_d = remaining_q - ADDR_ONE;
`ifdef BURST_READBACK_CHECK_EN
          checksum_d  = checksum_q ^ in_data;
`endif
          if (remaining_q == '0) begin
`ifdef BURST_READBACK_CHECK_EN
            // Rewind to the base and reuse remaining as the readback counter.
            state_d     = VERIFY;
            cur_addr_d  = base_q;
            remaining_d = len_q;
`else
            state_d     = DONE;
`endif
          end
        end
      end

`ifdef BURST_READBACK_CHECK_EN
      VERIFY: begin
        busy        = 1'b1;
        cur_addr_d  = cur_addr_q + ADDR_ONE;
        remaining_d = remaining_q - ADDR_ONE;
        // doa trails addra by a cycle, so the first VERIFY cycle has nothing to fold in yet.
        if (remaining_q != len_q) begin
          rd_sum_d = rd_sum_q ^ doa;
        end
        if (remaining_q == '0) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        busy    = 1'b1;
        err_d   = ((rd_sum_q ^ doa) != checksum_q);
        state_d = DONE;
      end
`endif

      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (rst) begin
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      wea       = 1'b0;
      dia       = '0;
      busy      = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
`ifdef BURST_READBACK_CHECK_EN
      base_q      <= '0;
      len_q       <= '0;
      checksum_q  <= '0;
      rd_sum_q    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
`ifdef BURST_READBACK_CHECK_EN
      base_q      <= base_d;
      len_q       <= len_d;
      checksum_q  <= checksum_d;
      rd_sum_q    <= rd_sum_d;
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_burst_write_ctrl.sv
// Self-checking bench for burst_write_ctrl: RAM model plus a write scoreboard.
module tb_burst_write_ctrl;
  localparam int AW = 4;
  localparam int DW = 4;
`ifdef BURST_READBACK_CHECK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dia;
  logic [DW-1:0] doa = '0;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  burst_write_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wea(wea), .addra(addra), .dia(dia), .doa(doa),
    .busy(busy), .done(done), .err(err)
  );

  // RAM model with one-cycle read latency and an optional corrupted location.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          corrupt = 1'b0;
  always @(posedge clk) begin
    if (wea) mem[addra] <= dia;
    doa <= (corrupt && addra == 4'd5) ? 4'd6 : mem[addra];
  end

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [AW+DW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (wea) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%h data=%h, no write expected", addra, dia);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({addra, dia} !== e) begin
          errors++;
          $display("FAIL write_beat: addr/data=%h/%h required %h/%h", addra, dia, e[7:4], e[3:0]);
        end
      end
      wr_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [AW-1:0] l);
    int n = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    while (cmd_ready !== 1'b1 && n < 20) begin cyc(); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
    end
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 64) begin cyc(); n++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; in_valid = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    checks++;
    if ({cmd_ready, in_ready, wea, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: cmd_ready/in_ready/wea/busy/done=%b required 00000",
               {cmd_ready, in_ready, wea, busy, done});
    end
    @(posedge clk); #1;
    rst = 1'b0; cmd_valid = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b err=%b required 1 0 0", cmd_ready, busy, err);
    end
    cyc();
  endtask

  task automatic test_basic();
    logic [DW-1:0] d [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    int w0, d0, n;
    w0 = wr_cnt; d0 = done_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back({4'(3 + i), d[i]});
    send_cmd(4'd3, 4'd3);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = d[i];
      @(negedge clk);
      checks++;
      if (wea !== 1'b1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_beat%0d: wea=%b in_ready=%b required 1 1", i, wea, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_data = '0;
    wait_done(n);
    checks++;
    if (n != (RB ? 6 : 1) || busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: latency=%0d busy=%b err=%b required %0d 1 0", n, busy, err, RB ? 6 : 1);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_after: done=%b busy=%b cmd_ready=%b required 0 0 1", done, busy, cmd_ready);
    end
    checks++;
    if (wr_cnt - w0 != 4 || done_cnt - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_counts: writes=%0d dones=%0d pending=%0d required 4 1 0",
               wr_cnt - w0, done_cnt - d0, exp_q.size());
    end
    cyc();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    int w0, d0, n;
    w0 = wr_cnt; d0 = done_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back({a[i], 4'(i + 1)});
    send_cmd(4'd14, 4'd3);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'(i + 1);
      cyc();
    end
    in_valid = 1'b0; in_data = '0;
    wait_done(n);
    checks++;
    if (n != (RB ? 6 : 1)) begin
      errors++;
      $display("FAIL wrap_done_latency: got %0d required %0d", n, RB ? 6 : 1);
    end
    repeat (3) cyc();
    checks++;
    if (wr_cnt - w0 != 4 || done_cnt - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_counts: writes=%0d dones=%0d pending=%0d required 4 1 0",
               wr_cnt - w0, done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_gapped();
    logic v [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [DW-1:0] d [4] = '{4'd7, 4'd2, 4'd3, 4'd9};
    int w0, n;
    w0 = wr_cnt;
    exp_q.push_back({4'd8, 4'd7});
    exp_q.push_back({4'd9, 4'd9});
    send_cmd(4'd8, 4'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = v[i]; in_data = d[i];
      @(negedge clk);
      checks++;
      if (wea !== v[i]) begin
        errors++;
        $display("FAIL gapped_wea%0d: got %b required %b", i, wea, v[i]);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_data = '0;
    wait_done(n);
    checks++;
    if (n != (RB ? 4 : 1) || wr_cnt - w0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL gapped_summary: latency=%0d writes=%0d pending=%0d required %0d 2 0",
               n, wr_cnt - w0, exp_q.size(), RB ? 4 : 1);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    w0 = wr_cnt; d0 = done_cnt;
    exp_q.push_back({4'd0, 4'd3});
    exp_q.push_back({4'd1, 4'd4});
    send_cmd(4'd0, 4'd4);
    cmd_valid = 1'b1; cmd_addr = 4'd9; cmd_len = 4'd0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 4'(3 + i);
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_cmd_ignored: cmd_ready=%b busy=%b required 0 1", cmd_ready, busy);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b1; in_data = 4'd5;
    @(negedge clk);
    checks++;
    if (wea !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: wea=%b busy=%b done=%b required 0 0 0", wea, busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; cmd_valid = 1'b0; in_data = '0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_release: cmd_ready=%b required 1", cmd_ready);
    end
    repeat (6) cyc();
    checks++;
    if (wr_cnt - w0 != 2 || done_cnt != d0 || exp_q.size() != 0 || mem[0] !== 4'd3 || mem[1] !== 4'd4) begin
      errors++;
      $display("FAIL abort_effects: writes=%0d dones=%0d mem0=%h mem1=%h required 2 0 3 4",
               wr_cnt - w0, done_cnt - d0, mem[0], mem[1]);
    end
  endtask

`ifdef BURST_READBACK_CHECK_EN
  task automatic test_readback();
    int n;
    for (int pass = 0; pass < 2; pass++) begin
      corrupt = (pass == 1);
      for (int i = 0; i < 4; i++) exp_q.push_back({4'(4 + i), 4'(4 + i)});
      send_cmd(4'd4, 4'd3);
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b1; in_data = 4'(4 + i);
        cyc();
      end
      in_valid = 1'b0; in_data = '0;
      wait_done(n);
      checks++;
      if (n != 6 || err !== corrupt) begin
        errors++;
        $display("FAIL readback_pass%0d: latency=%0d err=%b required 6 %b", pass, n, err, corrupt);
      end
      cyc();
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_hold: err=%b required 1", err);
    end
    corrupt = 1'b0;
    exp_q.push_back({4'd0, 4'd1});
    send_cmd(4'd0, 4'd0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b required 0", err);
    end
    in_valid = 1'b1; in_data = 4'd1;
    cyc();
    in_valid = 1'b0; in_data = '0;
    wait_done(n);
    checks++;
    if (n != 3 || err !== 1'b0) begin
      errors++;
      $display("FAIL readback_single: latency=%0d err=%b required 3 0", n, err);
    end
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_gapped();
    test_reset_mid();
`ifdef BURST_READBACK_CHECK_EN
    test_readback();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
